// File: rtl/up3_pkg.sv
// Shared UP3 types and widths used by the loader, RAM, PC and IR.
// Holds the loader state encoding (also shown on the debug/LED port).
package up3_pkg;

    localparam int UP3_ADDR_W  = 8;
    localparam int UP3_DATA_W  = 8;
    localparam int UP3_TIMEOUT = 50000;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LEN   = 3'd1,
        LD_LOAD  = 3'd2,
        LD_CHK   = 3'd3,
        LD_DONE  = 3'd4,
        LD_ERROR = 3'd5
    } loader_state_t;

endpackage

// File: rtl/up3_timeout_ctr.sv
// Idle-cycle watchdog for the boot loader.
// Ports: clk, reset (async, active-low), i_clear (restart count),
//   i_enable (count while high, held at 0 otherwise),
//   o_expired (high while count sits at TIMEOUT-1 and enabled).
// TIMEOUT=0 disables expiry entirely.
module up3_timeout_ctr #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] r_cnt;
    logic          w_hit;

    assign w_hit     = (TIMEOUT != 0) && (r_cnt == LIMIT);
    assign o_expired = i_enable && w_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable) begin
            r_cnt <= '0;
        end else if (!w_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/up3_boot_loader.sv
// UP3 program loader: streams a LEN/payload/CHK frame into program RAM
// from address 0, verifies the 8-bit sum, then releases the CPU.
// Ports: clk, reset (async, active-low), start (load pulse),
//   in_data/in_valid/in_ready (byte stream), ram_addr/ram_data/ram_wren
//   (RAM write port), cpu_run (CPU release), done/error (status levels),
//   state (FSM encoding for debug/LEDs).
module up3_boot_loader
    import up3_pkg::*;
#(
    parameter int ADDR_W  = UP3_ADDR_W,
    parameter int DATA_W  = UP3_DATA_W,
    parameter int TIMEOUT = UP3_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              cpu_run,
    output logic              done,
    output logic              error,
    output logic [2:0]        state
);

    // LEN byte of zero means a full 2**DATA_W payload
    localparam logic [DATA_W:0] FULL = {1'b1, {DATA_W{1'b0}}};

    loader_state_t     r_state;
    logic [DATA_W:0]   r_count;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_chk;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    logic              r_in_ready;
    logic              r_cpu_run;
    logic              r_done;
    logic              r_error;

    logic w_acc;
    logic w_active;
    logic w_exp;

    assign w_acc    = in_valid && r_in_ready;
    assign w_active = (r_state == LD_LEN) ||
                      (r_state == LD_LOAD) ||
                      (r_state == LD_CHK);

    up3_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_acc),
        .i_enable  (w_active),
        .o_expired (w_exp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= LD_IDLE;
            r_count    <= '0;
            r_ptr      <= '0;
            r_chk      <= '0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_wren <= 1'b0;
            r_in_ready <= 1'b0;
            r_cpu_run  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_ram_wren <= 1'b0;
            unique case (r_state)
                LD_IDLE, LD_DONE, LD_ERROR: begin
                    if (start) begin
                        r_state    <= LD_LEN;
                        r_in_ready <= 1'b1;
                        r_cpu_run  <= 1'b0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                LD_LEN: begin
                    if (w_acc) begin
                        r_state <= LD_LOAD;
                        r_count <= (in_data == '0) ? FULL
                                                   : {1'b0, in_data};
                        r_chk   <= in_data;
                        r_ptr   <= '0;
                    end else if (w_exp) begin
                        r_state    <= LD_ERROR;
                        r_error    <= 1'b1;
                        r_in_ready <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (w_acc) begin
                        r_ram_wren <= 1'b1;
                        r_ram_addr <= r_ptr;
                        r_ram_data <= in_data;
                        r_ptr      <= r_ptr + 1'b1;
                        r_chk      <= r_chk + in_data;
                        r_count    <= r_count - 1'b1;
                        if (r_count == {{DATA_W{1'b0}}, 1'b1}) begin
                            r_state <= LD_CHK;
                        end
                    end else if (w_exp) begin
                        r_state    <= LD_ERROR;
                        r_error    <= 1'b1;
                        r_in_ready <= 1'b0;
                    end
                end
                LD_CHK: begin
                    if (w_acc) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_chk) begin
                            r_state   <= LD_DONE;
                            r_done    <= 1'b1;
                            r_cpu_run <= 1'b1;
                        end else begin
                            r_state <= LD_ERROR;
                            r_error <= 1'b1;
                        end
                    end else if (w_exp) begin
                        r_state    <= LD_ERROR;
                        r_error    <= 1'b1;
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= LD_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign ram_wren = r_ram_wren;
    assign cpu_run  = r_cpu_run;
    assign done     = r_done;
    assign error    = r_error;
    assign state    = r_state;

endmodule

// File: tb/tb_up3_boot_loader.sv
// Scoreboard bench for up3_boot_loader: frames are modelled as byte
// lists, expected RAM writes queued and popped by a write monitor.
module tb_up3_boot_loader;
    import up3_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic       cpu_run;
    logic       done;
    logic       error;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  payload[$];
    logic [15:0] w;

    up3_boot_loader #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .cpu_run  (cpu_run),
        .done     (done),
        .error    (error),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (ram_wren) begin
                check("write_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", ram_addr, w[15:8]);
                    check("wr_data", ram_data, w[7:0]);
                end
                check("wren_with_run", cpu_run, 0);
            end
            check("ready_vs_state", in_ready,
                  (state >= 3'd1) && (state <= 3'd3));
        end
    end

    task automatic check_reset_vals();
        check("rst_state", state, 0);
        check("rst_ready", in_ready, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_run", cpu_run, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        bit ok;
        gap = $urandom_range(0, maxgap);
        ok = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = b;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_bound", 0, 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_state", state, 1);
        check("start_ready", in_ready, 1);
        check("start_run", cpu_run, 0);
    endtask

    task automatic valid_noise(input int cycles, input logic [2:0] st);
        repeat (cycles) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("noise_state", state, st);
    endtask

    // chk_force < 0: model sum (or corrupted sum when corrupt=1)
    task automatic run_frame(input bit corrupt, input int maxgap,
                             input int chk_force);
        logic [7:0] lenb;
        logic [7:0] sum;
        logic [7:0] cb;
        bit good;
        lenb = 8'(payload.size());
        sum = lenb;
        foreach (payload[i]) begin
            exp_wr.push_back({8'(i), payload[i]});
            sum = sum + payload[i];
        end
        if (chk_force >= 0) cb = 8'(chk_force);
        else if (corrupt) cb = sum ^ 8'($urandom_range(1, 255));
        else cb = sum;
        good = (cb == sum);
        do_start();
        send_byte(lenb, maxgap);
        foreach (payload[i]) send_byte(payload[i], maxgap);
        send_byte(cb, maxgap);
        check("frm_done", done, good);
        check("frm_error", error, !good);
        check("frm_run", cpu_run, good);
        check("frm_state", state, good ? 3'd4 : 3'd5);
        @(negedge clk);
        #1;
        check("writes_drained", exp_wr.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b1;
        @(posedge clk);
        #1;

        valid_noise(8, 3'd0);

        // reset mid-LOAD after three payload bytes
        do_start();
        send_byte(8'd8, 1);
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back({8'(i), 8'(8'hA0 + i)});
            send_byte(8'(8'hA0 + i), 1);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals();
        check("rst_drained", exp_wr.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(1'b0, 0, 8'hAE);
        valid_noise(10, 3'd4);
        check("idle_done_hold", done, 1);

        run_frame(1'b0, 2, 8'hAF);

        payload.delete();
        repeat (256) payload.push_back(8'h01);
        run_frame(1'b0, 1, 8'h00);

        // timeout: 15 idle cycles tolerated, 16th expires
        do_start();
        send_byte(8'd4, 0);
        exp_wr.push_back({8'h00, 8'h5A});
        exp_wr.push_back({8'h01, 8'hC3});
        send_byte(8'h5A, 0);
        send_byte(8'hC3, 0);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        check("tmo_not_yet", error, 0);
        check("tmo_load", state, 2);
        @(posedge clk);
        #1;
        check("tmo_error", error, 1);
        check("tmo_state", state, 5);
        check("tmo_ready", in_ready, 0);
        check("tmo_drained", exp_wr.size(), 0);

        payload.delete();
        repeat (6) payload.push_back(8'($urandom));
        run_frame(1'b0, 3, -1);

        for (int f = 0; f < 8; f++) begin
            payload.delete();
            repeat ($urandom_range(1, 24)) payload.push_back(8'($urandom));
            run_frame(1'($urandom_range(0, 1)), 3, -1);
        end

        check("final_drained", exp_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
